// File: rtl/sevenseg_scan_decoder.sv
// Receiver for a two-digit multiplexed seven-segment display: debounces the
// anode/segment lines, decodes each lit digit and reassembles the shown byte.
module sevenseg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       an0,
    input  logic       an1,
    input  logic [6:0] seg,
    output logic [7:0] value,
    output logic       value_valid,
    output logic       digit_err,
    output logic       stale
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0]    STAB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_SCAN  = 2'd0;
    localparam logic [1:0] S_HAVE0 = 2'd1;
    localparam logic [1:0] S_HAVE1 = 2'd2;
    localparam logic [1:0] S_EMIT  = 2'd3;

    logic [8:0]    sync1_q, sync2_q, prev_q;
    logic [7:0]    stab_q, stab_d;
    logic          done_q, done_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    lo_q, lo_d, hi_q, hi_d;
    logic [7:0]    value_q, value_d;
    logic          valid_q, valid_d, err_q, err_d, stale_q, stale_d, first_q, first_d;
    logic [TW-1:0] to_q, to_d;
    logic          pend_q, pend_d, pend_dig_q, pend_dig_d;
    logic [3:0]    pend_nib_q, pend_nib_d;

    logic       a0_n, a1_n, stable, accept, one_hot, hit, cap, ev, ev_dig;
    logic [6:0] seg_n;
    logic [3:0] nib, ev_nib;
    logic [7:0] new_byte;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = 5'h10;  7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;  7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;  7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;  7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;  7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;  7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;  7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;  7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign a0_n    = sync2_q[8] ^ AN_ACTIVE_LOW;
    assign a1_n    = sync2_q[7] ^ AN_ACTIVE_LOW;
    assign seg_n   = sync2_q[6:0] ^ {7{SEG_ACTIVE_LOW}};
    assign stable  = (sync2_q == prev_q);
    // done_q limits acceptance to one per stable period while the counter sits saturated
    assign accept  = stable && (stab_q == STAB_LAST) && !done_q;
    assign one_hot = a0_n ^ a1_n;
    assign {hit, nib} = decode(seg_n);
    assign cap     = accept && one_hot && hit;
    assign ev      = cap || pend_q;
    assign ev_dig  = pend_q ? pend_dig_q : a1_n;
    assign ev_nib  = pend_q ? pend_nib_q : nib;

    always_comb begin
        stab_d     = stab_q;
        done_d     = done_q;
        state_d    = state_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        value_d    = value_q;
        valid_d    = 1'b0;
        err_d      = accept && one_hot && !hit;
        stale_d    = stale_q;
        first_d    = first_q;
        to_d       = to_q;
        pend_d     = 1'b0;
        pend_dig_d = pend_dig_q;
        pend_nib_d = pend_nib_q;
        new_byte   = 8'h00;

        if (!stable) begin
            stab_d = 8'h00;
            done_d = 1'b0;
        end else begin
            if (stab_q != STAB_LAST) stab_d = stab_q + 8'h01;
            if (accept) done_d = 1'b1;
        end

        case (state_q)
            S_SCAN: if (ev) begin
                if (ev_dig) begin hi_d = ev_nib; state_d = S_HAVE1; end
                else        begin lo_d = ev_nib; state_d = S_HAVE0; end
            end
            S_HAVE0: if (ev) begin
                if (ev_dig) begin hi_d = ev_nib; state_d = S_EMIT; end
                else        lo_d = ev_nib;
            end
            S_HAVE1: if (ev) begin
                if (!ev_dig) begin lo_d = ev_nib; state_d = S_EMIT; end
                else         hi_d = ev_nib;
            end
            default: begin
                // A capture landing on the emit cycle is replayed from S_SCAN next cycle
                state_d = S_SCAN;
                if (cap) begin
                    pend_d     = 1'b1;
                    pend_dig_d = a1_n;
                    pend_nib_d = nib;
                end
            end
        endcase

        // Outputs are registered on entry so the strobe cycle coincides with S_EMIT
        if (state_d == S_EMIT) begin
            new_byte = {hi_d, lo_d};
            to_d     = '0;
            stale_d  = 1'b0;
            if (first_q || (new_byte != value_q)) begin
                value_d = new_byte;
                valid_d = 1'b1;
                first_d = 1'b0;
            end
        end else begin
            if (to_q != TO_LAST) to_d = to_q + 1'b1;
            if (to_d == TO_LAST) stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            stab_q     <= '0;
            done_q     <= 1'b0;
            state_q    <= S_SCAN;
            lo_q       <= '0;
            hi_q       <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            stale_q    <= 1'b0;
            first_q    <= 1'b1;
            to_q       <= '0;
            pend_q     <= 1'b0;
            pend_dig_q <= 1'b0;
            pend_nib_q <= '0;
        end else begin
            sync1_q    <= {an0, an1, seg};
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            stab_q     <= stab_d;
            done_q     <= done_d;
            state_q    <= state_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            stale_q    <= stale_d;
            first_q    <= first_d;
            to_q       <= to_d;
            pend_q     <= pend_d;
            pend_dig_q <= pend_dig_d;
            pend_nib_q <= pend_nib_d;
        end
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign digit_err   = err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Self-checking bench for sevenseg_scan_decoder: expected bytes are queued as
// scans are driven and checked against each value_valid strobe.
module tb_sevenseg_scan_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       an0 = 1'b1;
    logic       an1 = 1'b1;
    logic [6:0] seg = 7'h7F;
    logic [7:0] value;
    logic       value_valid, digit_err, stale;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int errs   = 0;
    logic [7:0] exp_q[$];

    sevenseg_scan_decoder #(
        .STABLE_CYCLES(4), .TIMEOUT_CYCLES(50), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .an0(an0), .an1(an1), .seg(seg),
        .value(value), .value_valid(value_valid), .digit_err(digit_err), .stale(stale)
    );

    always #5 clk = ~clk;

    // Scoreboard: every strobe pops and compares one expected byte
    always @(negedge clk) begin
        if (rst) begin
            if (value_valid) begin
                pulses++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid got=%02h want=no strobe", value);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (value !== e) begin
                        bad++;
                        $display("FAIL sb_value got=%02h want=%02h", value, e);
                    end else
                        $display("strobe value=%02h ok", value);
                end
            end
            if (digit_err) errs++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic d0(input logic [6:0] code, input int n);
        an0 = 1'b0; an1 = 1'b1; seg = ~code;
        hold(n);
    endtask

    task automatic d1(input logic [6:0] code, input int n);
        an0 = 1'b1; an1 = 1'b0; seg = ~code;
        hold(n);
    endtask

    task automatic idle(input int n);
        an0 = 1'b1; an1 = 1'b1; seg = 7'h7F;
        hold(n);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle(3);
        total++; if ({value, value_valid, digit_err, stale} !== 11'h0) begin
            bad++; $display("FAIL reset_hold got=%02h/%b/%b/%b want=00/0/0/0", value, value_valid, digit_err, stale);
        end
        rst = 1'b1;
        hold(1);
        total++; if ({value, value_valid, digit_err, stale} !== 11'h0) begin
            bad++; $display("FAIL reset_release got=%02h/%b/%b/%b want=00/0/0/0", value, value_valid, digit_err, stale);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_scan;
        int p0, e0, lat;
        p0 = pulses; e0 = errs; lat = 0;
        d0(7'h4F, 8);
        exp_q.push_back(8'h53);
        an0 = 1'b1; an1 = 1'b0; seg = ~7'h6D;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (value_valid && lat == 0) lat = c;
        end
        total++; if (lat !== 7) begin bad++; $display("FAIL scan_latency got=%0d want=7", lat); end
        total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL scan_pulses got=%0d want=1", pulses - p0); end
        total++; if (value !== 8'h53) begin bad++; $display("FAIL scan_value got=%02h want=53", value); end
        total++; if (errs - e0 !== 0) begin bad++; $display("FAIL scan_err got=%0d want=0", errs - e0); end
        $display("test_basic_scan latency=%0d", lat);
    endtask

    task automatic test_back_to_back;
        int p0;
        p0 = pulses;
        for (int r = 0; r < 3; r++) begin
            d0(7'h4F, 8);
            d1(7'h6D, 8);
        end
        total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL repeat_silent got=%0d want=0", pulses - p0); end
        d0(7'h4F, 8);
        exp_q.push_back(8'hF3);
        d1(7'h71, 8);
        idle(8);
        total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL change_pulses got=%0d want=1", pulses - p0); end
        total++; if (value !== 8'hF3) begin bad++; $display("FAIL change_value got=%02h want=F3", value); end
        $display("test_back_to_back done");
    endtask

    task automatic test_glitch;
        int p0, e0;
        p0 = pulses; e0 = errs;
        for (int g = 0; g < 10; g++) d0(g[0] ? 7'h5B : 7'h06, 2);
        idle(8);
        total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", pulses - p0); end
        total++; if (errs - e0 !== 0) begin bad++; $display("FAIL glitch_err got=%0d want=0", errs - e0); end
        // Digit 1 first: emits too early if the glitch had left the FSM holding a nibble
        d1(7'h6D, 8);
        exp_q.push_back(8'h53);
        d0(7'h4F, 8);
        idle(8);
        total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL glitch_after got=%0d want=1", pulses - p0); end
        $display("test_glitch done");
    endtask

    task automatic test_bad_digit;
        int p0, e0;
        p0 = pulses; e0 = errs;
        d0(7'h01, 8);
        total++; if (errs - e0 !== 1) begin bad++; $display("FAIL bad_digit_err got=%0d want=1", errs - e0); end
        total++; if (value !== 8'h53) begin bad++; $display("FAIL bad_digit_value got=%02h want=53", value); end
        an0 = 1'b0; an1 = 1'b0; seg = ~7'h3F;
        hold(10);
        idle(8);
        total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL both_valid got=%0d want=0", pulses - p0); end
        total++; if (errs - e0 !== 1) begin bad++; $display("FAIL both_err got=%0d want=1", errs - e0); end
        $display("test_bad_digit done");
    endtask

    task automatic test_timeout_reset;
        logic seen;
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        for (int c = 1; c <= 49; c++) begin
            @(negedge clk);
            if (c == 48) begin
                total++; if (stale !== 1'b0) begin bad++; $display("FAIL stale_early got=%b want=0", stale); end
            end
        end
        total++; if (stale !== 1'b1) begin bad++; $display("FAIL stale_49 got=%b want=1", stale); end
        d0(7'h4F, 8);
        exp_q.push_back(8'h53);
        an0 = 1'b1; an1 = 1'b0; seg = ~7'h6D;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (value_valid) begin
                seen = 1'b1;
                total++; if (stale !== 1'b0) begin bad++; $display("FAIL stale_clear got=%b want=0", stale); end
            end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL stale_scan got=%b want=1", seen); end
        // Leave a partial digit-0 nibble held, then reset between clock edges
        d0(7'h4F, 8);
        #3 rst = 1'b0;
        #1;
        total++; if ({value, value_valid, digit_err, stale} !== 11'h0) begin
            bad++; $display("FAIL async_reset got=%02h/%b/%b/%b want=00/0/0/0", value, value_valid, digit_err, stale);
        end
        an0 = 1'b1; an1 = 1'b1; seg = 7'h7F;
        hold(2);
        rst = 1'b1;
        idle(4);
        d1(7'h3F, 8);
        exp_q.push_back(8'h00);
        d0(7'h3F, 8);
        idle(4);
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL first_after_reset got=%0d pending want=0", exp_q.size()); end
        $display("test_timeout_reset done");
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_back_to_back();
        test_glitch();
        test_bad_digit();
        test_timeout_reset();
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL missing_strobes got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
